dot_accumulator: RTL and testbench
==================================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 8, signed product width (matches 4x4 multiplier output z).
REQ-002 SHALL have parameter ACC_W, default 16, signed accumulator width; ACC_W >= PROD_W+2.
REQ-003 SHALL have parameter LEN, default 4, products per result (1..8).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  product word valid.
REQ-008 SHALL have port in_ready  output  1  block accepts product this cycle.
REQ-009 SHALL have port in_prod  input  PROD_W  signed two's-complement product.
REQ-010 SHALL have port in_last  input  1  final product of the current vector (early terminate).
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_acc  output  ACC_W  signed accumulated sum.
REQ-014 SHALL have port out_cnt  output  4  number of products summed (1..LEN).
REQ-015 SHALL have port out_ovf  output  1  overflow occurred in this result.

Function
REQ-016 SHALL implement FSM with states ACCUM and HOLD; reset state ACCUM.
REQ-017 ACCUM: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1.
REQ-018 Input accepted only on in_valid&&in_ready; accept: acc <= acc + sign-extended in_prod, cnt <= cnt+1.
REQ-019 Accept with cnt==LEN-1 or in_last=1 SHALL transition to HOLD; out_valid asserts the cycle after that accept (latency 1).
REQ-020 HOLD: out_acc/out_cnt/out_ovf SHALL stay stable until out_valid&&out_ready.
REQ-021 Output handshake SHALL clear acc, cnt, ovf and return to ACCUM; new input accepted no earlier than the next cycle.
REQ-022 in_prod/in_last SHALL be ignored when in_ready=0; in_last with in_valid=0 SHALL have no effect.
REQ-023 Signed overflow of an ACC_W addition SHALL set sticky ovf for the current result.
REQ-024 Without saturation, overflowing sums SHALL wrap modulo 2^ACC_W.

Reset
REQ-025 rst SHALL asynchronously force state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1 after release.
REQ-026 rst mid-vector or in HOLD SHALL discard partial/pending result without emitting it.

Configuration
REQ-027 Macro DOT_ACCUMULATOR_SAT_EN defined: overflowing additions SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), ovf still set.
REQ-028 Macro undefined: wrap behaviour per REQ-024; no clamp logic synthesized.

Structure
REQ-029 Shared package SHALL hold PROD_W/ACC_W/LEN defaults and the FSM state enum (ACCUM, HOLD).
REQ-030 Add/overflow/clamp logic SHALL be a sub-module sat_adder (combinational, ACC_W wide).

Verification
REQ-031 Products 6,-15,49,-4 (LEN=4), out_ready=1 -> one result out_acc=36, out_cnt=4, ovf=0, out_valid 1 cycle after 4th accept.
REQ-032 Products 10,20 with in_last on 20 -> out_acc=30, out_cnt=2; next vector starts from 0.
REQ-033 Result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no input consumed; out_ready=1 -> release, then accept resumes.
REQ-034 ACC_W=8, products 100,100 -> wrap: out_acc=-56, ovf=1; with DOT_ACCUMULATOR_SAT_EN: out_acc=127, ovf=1.
REQ-035 rst pulsed after 2 of 4 products -> no out_valid; fresh vector 1,1,1,1 -> out_acc=4, out_cnt=4.
REQ-036 Back-to-back vectors with continuous in_valid and out_ready=1 -> every product accepted exactly once, one bubble per result.

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
// Shared defaults and FSM state type for the dot-product accumulator.
package dot_accumulator_pkg;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned LEN_DEF    = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/dot_accumulator_sat_adder.sv
// Combinational ACC_W-wide signed adder with overflow flag.
// Clamps on overflow when DOT_ACCUMULATOR_SAT_EN is defined, otherwise wraps.
module sat_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         ovf_c
);

  logic [W-1:0] raw;
  logic         ovf;

  always_comb begin
    raw   = a + b;
    ovf   = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    ovf_c = ovf;
    sum_c = raw;
`ifdef DOT_ACCUMULATOR_SAT_EN
    // Both operands share a sign on overflow, so a's sign picks the rail.
    if (ovf) begin
      sum_c = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates LEN signed products (or fewer, on in_last) into one result held
// until handshaken. Optional clamping via DOT_ACCUMULATOR_SAT_EN.
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_c;
  logic               add_ovf_c;
  logic               accept_c;
  logic               release_c;

  assign prod_ext = ACC_W'(in_prod);

  sat_adder #(
    .W (ACC_W)
  ) u_sat_adder (
    .a     (acc_q),
    .b     (prod_ext),
    .sum_c (sum_c),
    .ovf_c (add_ovf_c)
  );

  assign accept_c  = in_valid && in_ready_q;
  assign release_c = out_valid_q && out_ready;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (state_q == ACCUM) begin
      if (accept_c) begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf_c;
        if (in_last || (cnt_q == LAST_CNT)) begin
          state_d = HOLD;
        end
      end
    end else begin
      if (release_c) begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
    end
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench for dot_accumulator (PROD_W=8, ACC_W=8, LEN=4).
// Expected overflow results follow DOT_ACCUMULATOR_SAT_EN.
module tb_dot_accumulator;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_acc;
  logic [3:0]        out_cnt;
  logic              out_ovf;

  int   checks   = 0;
  int   failures = 0;
  int   stalls   = 0;
  int   sent     = 0;
  exp_t sb[$];

  dot_accumulator #(
    .PROD_W (8),
    .ACC_W  (8),
    .LEN    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void expect_res(input int acc, input int cnt, input int ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.ovf = ovf;
    sb.push_back(e);
  endfunction

  // Monitor: sample after negedge drives settle; handshake completes at next posedge
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_acc", int'(out_acc), e.acc);
        check("out_cnt", int'(out_cnt), e.cnt);
        check("out_ovf", int'(out_ovf), e.ovf);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input int p, input logic l);
    in_valid = 1'b1;
    in_prod  = 8'(p);
    in_last  = l;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        @(posedge clk);
        sent++;
        @(negedge clk);
        return;
      end
      stalls++;
      @(negedge clk);
    end
    check("send_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int sat_a, sat_b, sat_c, exp_sent;

  initial begin
`ifdef DOT_ACCUMULATOR_SAT_EN
    sat_a = 127; sat_b = 117; sat_c = -128;
`else
    sat_a = -56; sat_b = -56; sat_c = 56;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_out_acc", int'(out_acc), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-length vector, latency 1 after fourth accept
    expect_res(36, 4, 0);
    send(6, 1'b0);
    send(-15, 1'b0);
    send(49, 1'b0);
    check("pre_last_out_valid", int'(out_valid), 0);
    send(-4, 1'b0);
    check("lat_out_valid", int'(out_valid), 1);
    check("lat_in_ready", int'(in_ready), 0);
    idle(2);

    // Early termination, then next vector starts from zero
    expect_res(30, 2, 0);
    send(10, 1'b0);
    send(20, 1'b1);
    idle(1);
    expect_res(3, 2, 0);
    send(1, 1'b0);
    send(2, 1'b1);
    idle(2);
    // in_last without in_valid must be ignored
    in_last = 1'b1;
    @(negedge clk);
    check("last_no_valid_out_valid", int'(out_valid), 0);
    check("last_no_valid_cnt", int'(out_cnt), 0);
    in_last = 1'b0;

    // Backpressure: result held, no input consumed
    out_ready = 1'b0;
    expect_res(15, 2, 0);
    send(7, 1'b0);
    send(8, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'(3);
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_acc", int'(out_acc), 15);
      check("hold_out_cnt", int'(out_cnt), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_res(3, 1, 0);
    send(3, 1'b1);
    idle(2);

    // Overflow: wrap or clamp, sticky flag
    expect_res(sat_a, 2, 1);
    send(100, 1'b0);
    send(100, 1'b1);
    idle(1);
    expect_res(sat_b, 4, 1);
    send(100, 1'b0);
    send(100, 1'b0);
    send(10, 1'b0);
    send(-10, 1'b0);
    idle(1);
    expect_res(sat_c, 2, 1);
    send(-100, 1'b0);
    send(-100, 1'b1);
    idle(2);

    // Reset mid-vector discards partial result
    send(5, 1'b0);
    send(5, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_out_cnt", int'(out_cnt), 0);
    check("midrst_out_acc", int'(out_acc), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    expect_res(4, 4, 0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    idle(2);

    // Back-to-back vectors with continuous valid: one bubble per result
    stalls   = 0;
    exp_sent = sent + 8;
    expect_res(10, 4, 0);
    expect_res(26, 4, 0);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b0);
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b0);
    idle(3);
    check("b2b_stalls", stalls, 1);
    check("b2b_sent", sent, exp_sent);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
